// File: rtl/word_handshake_buffer.sv
// Ready/valid FIFO of DEPTH words: a push shows on output_data the cycle after its edge, one word per cycle sustained.
// Backpressure: input_ready drops only at full. Flags come from the registered count, so no ready/valid comb paths.
module word_handshake_buffer #(
   parameter int WORD_WIDTH  = 8,
   parameter int DEPTH       = 4,
   parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic                   input_valid,
   output logic                   input_ready,
   input  logic [WORD_WIDTH-1:0]  input_data,
   output logic                   output_valid,
   input  logic                   output_ready,
   output logic [WORD_WIDTH-1:0]  output_data,
   output logic [COUNT_WIDTH-1:0] item_count
);

   localparam int PTR_WIDTH = $clog2(DEPTH);
   localparam logic [PTR_WIDTH-1:0]   LAST_PTR  = PTR_WIDTH'(DEPTH - 1);
   localparam logic [COUNT_WIDTH-1:0] FULL_CNT  = COUNT_WIDTH'(DEPTH);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
   localparam logic [PTR_WIDTH-1:0]   PTR_ONE   = PTR_WIDTH'(1);

   logic [WORD_WIDTH-1:0]  mem_q [DEPTH];
   logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   push, pop;

   assign input_ready  = (count_q != FULL_CNT);
   assign output_valid = (count_q != '0);
   assign item_count   = count_q;
   // Masked so a cleared buffer shows zero without having to wipe the memory.
   assign output_data  = output_valid ? mem_q[rd_ptr_q] : '0;

   assign push = input_valid && input_ready;
   assign pop  = output_valid && output_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push && !clear) begin
         mem_q[wr_ptr_q] <= input_data;
      end
   end

endmodule

// File: tb/tb_word_handshake_buffer.sv
// Directed bench for word_handshake_buffer: DEPTH=4 scenarios plus a DEPTH=3 randomised wrap run against a queue.
module tb_word_handshake_buffer;

   logic       clock = 1'b0;
   logic       clear;

   logic       iv4, ir4, ov4, or4;
   logic [7:0] id4, od4;
   logic [2:0] cnt4;

   logic       iv3, ir3, ov3, or3;
   logic [7:0] id3, od3;
   logic [1:0] cnt3;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   word_handshake_buffer #(.WORD_WIDTH(8), .DEPTH(4)) dut4 (
      .clock(clock), .clear(clear),
      .input_valid(iv4), .input_ready(ir4), .input_data(id4),
      .output_valid(ov4), .output_ready(or4), .output_data(od4),
      .item_count(cnt4)
   );

   word_handshake_buffer #(.WORD_WIDTH(8), .DEPTH(3)) dut3 (
      .clock(clock), .clear(clear),
      .input_valid(iv3), .input_ready(ir3), .input_data(id3),
      .output_valid(ov3), .output_ready(or3), .output_data(od3),
      .item_count(cnt3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   logic [7:0] ref_q[$];

   initial begin
      int sent;
      int rcvd;
      int cyc;
      logic do_push, do_pop;

      clear = 1'b0;
      iv4 = 1'b0; id4 = '0; or4 = 1'b0;
      iv3 = 1'b0; id3 = '0; or3 = 1'b0;

      // Reset with a push offered: nothing may be stored.
      clear = 1'b1; iv4 = 1'b1; id4 = 8'h77;
      tick();
      clear = 1'b0; iv4 = 1'b0;
      check("rst_count", 32'(cnt4), 32'd0);
      check("rst_in_rdy", 32'(ir4), 32'd1);
      check("rst_out_vld", 32'(ov4), 32'd0);
      check("rst_out_dat", 32'(od4), 32'd0);
      check("rst3_count", 32'(cnt3), 32'd0);
      tick();
      check("rst_no_store", 32'(cnt4), 32'd0);

      // Fill with consumer stalled; fifth word must be refused.
      or4 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         iv4 = 1'b1; id4 = 8'hA0 + 8'(i);
         check("fill_in_rdy", 32'(ir4), (i < 4) ? 32'd1 : 32'd0);
         tick();
      end
      iv4 = 1'b0;
      check("full_count", 32'(cnt4), 32'd4);
      check("full_in_rdy", 32'(ir4), 32'd0);
      check("full_head", 32'(od4), 32'hA0);
      tick();
      check("stall_vld", 32'(ov4), 32'd1);
      check("stall_dat", 32'(od4), 32'hA0);

      // Full cycle with pop and push offered: only the pop happens.
      or4 = 1'b1; iv4 = 1'b1; id4 = 8'hB0;
      tick();
      iv4 = 1'b0;
      check("fullpop_count", 32'(cnt4), 32'd3);
      check("fullpop_in_rdy", 32'(ir4), 32'd1);
      for (int i = 1; i < 4; i++) begin
         check("drain_vld", 32'(ov4), 32'd1);
         check("drain_dat", 32'(od4), 32'hA0 + 32'(i));
         tick();
      end
      check("drain_empty_vld", 32'(ov4), 32'd0);
      check("drain_empty_cnt", 32'(cnt4), 32'd0);
      check("drain_empty_dat", 32'(od4), 32'd0);

      // Streaming: one word per cycle, occupancy steady at one.
      or4 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         iv4 = 1'b1; id4 = 8'(i);
         tick();
         check("stream_cnt", 32'(cnt4), 32'd1);
         check("stream_dat", 32'(od4), 32'(i));
      end
      iv4 = 1'b0;
      tick();
      check("stream_end_cnt", 32'(cnt4), 32'd0);

      // Clear beats a concurrent push and pop.
      or4 = 1'b0;
      iv4 = 1'b1; id4 = 8'h11; tick();
      id4 = 8'h22; tick();
      iv4 = 1'b0;
      check("pre_clear_cnt", 32'(cnt4), 32'd2);
      clear = 1'b1; iv4 = 1'b1; id4 = 8'h33; or4 = 1'b1;
      tick();
      clear = 1'b0; iv4 = 1'b0; or4 = 1'b0;
      check("clr_cnt", 32'(cnt4), 32'd0);
      check("clr_vld", 32'(ov4), 32'd0);
      check("clr_dat", 32'(od4), 32'd0);
      check("clr_in_rdy", 32'(ir4), 32'd1);
      iv4 = 1'b1; id4 = 8'h55; tick();
      iv4 = 1'b0;
      check("post_clr_vld", 32'(ov4), 32'd1);
      check("post_clr_dat", 32'(od4), 32'h55);
      or4 = 1'b1; tick(); or4 = 1'b0;
      check("post_clr_cnt", 32'(cnt4), 32'd0);

      // DEPTH=3 random handshakes against a reference queue.
      sent = 0; rcvd = 0; cyc = 0;
      while (rcvd < 100 && cyc < 3000) begin
         iv3 = (sent < 100) && ($urandom_range(0, 1) == 1);
         id3 = 8'(sent + 16);
         or3 = ($urandom_range(0, 1) == 1);
         check("r3_cnt", 32'(cnt3), 32'(ref_q.size()));
         check("r3_in_rdy", 32'(ir3), (ref_q.size() != 3) ? 32'd1 : 32'd0);
         check("r3_out_vld", 32'(ov3), (ref_q.size() != 0) ? 32'd1 : 32'd0);
         do_push = iv3 && (ref_q.size() != 3);
         do_pop  = or3 && (ref_q.size() != 0);
         if (do_pop) begin
            check("r3_dat", 32'(od3), 32'(ref_q[0]));
            void'(ref_q.pop_front());
            rcvd++;
         end
         if (do_push) begin
            ref_q.push_back(id3);
            sent++;
         end
         tick();
         cyc++;
      end
      iv3 = 1'b0; or3 = 1'b0;
      check("r3_all_received", 32'(rcvd), 32'd100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
